// File: rtl/fsc_stream_ctrl_if.sv
// Bundle between the stream controller, the stage datapaths and the FSC scratch memory.
// master = controller side; slave = environment (datapaths + FSC banks).
interface fsc_stream_ctrl_if #(
   parameter int DW = 64,
   parameter int AW = 6
);
   logic                  start;
   logic                  mode;
   logic                  busy;
   logic                  done;
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0][DW-1:0]    in_d;
   logic                  out_valid;
   logic                  out_ready;
   logic [3:0][DW-1:0]    out_d;
   logic                  we;
   logic [3:0][AW-1:0]    addr;
   logic [3:0][DW-1:0]    d;
   logic [3:0][DW-1:0]    q;

   modport master (
      input  start, mode, in_valid, in_d, out_ready, q,
      output busy, done, in_ready, out_valid, out_d, we, addr, d
   );

   modport slave (
      output start, mode, in_valid, in_d, out_ready, q,
      input  busy, done, in_ready, out_valid, out_d, we, addr, d
   );
endinterface

// File: rtl/fsc_stream_ctrl.sv
// Loads a 4-lane frame into the 4-bank FSC with a skewed layout, then streams it back
// in direct or 4x4-transposed order through a 2-entry skid FIFO.
module fsc_stream_ctrl #(
   parameter int DW = 64,
   parameter int AW = 6
) (
   input  logic             clk,
   input  logic             rstn,
   fsc_stream_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

   state_t                   state;
   logic                     mode_q;
   logic                     busy, done, in_ready;
   logic [AW-1:0]            ld_i;
   logic [AW:0]              rd_j;
   logic [AW-1:0]            out_cnt;
   logic                     inflight;
   logic [1:0]               tag_rot;
   logic [1:0][3:0][DW-1:0]  fifo_mem;
   logic                     wptr, rptr;
   logic [1:0]               occ;

   logic                     in_hs, pop, issue;
   logic                     we;
   logic [3:0][AW-1:0]       addr;
   logic [3:0][DW-1:0]       d, cap;

   assign in_hs = bus.in_valid & in_ready;
   assign pop   = (occ != 2'd0) & bus.out_ready;
   // Space check counts the read in flight so the FIFO can never overflow.
   assign issue = (state == READ) & ~rd_j[AW] &
                  (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

   always_comb begin
      we   = 1'b0;
      addr = '0;
      d    = '0;
      if (state == LOAD && in_hs) begin
         we = 1'b1;
         for (int n = 0; n < 4; n++) begin
            addr[n] = ld_i;
            d[n]    = bus.in_d[2'(n) - ld_i[1:0]];
         end
      end else if (issue) begin
         for (int n = 0; n < 4; n++)
            addr[n] = mode_q ? {rd_j[AW-1:2], 2'(2'(n) - rd_j[1:0])} : rd_j[AW-1:0];
      end
   end

   // Both orders undo the load skew the same way: lane b comes from bank (b+j)&3.
   always_comb begin
      cap = '0;
      for (int b = 0; b < 4; b++)
         cap[b] = bus.q[2'(b) + tag_rot];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         mode_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         in_ready <= 1'b0;
         ld_i     <= '0;
         rd_j     <= '0;
         out_cnt  <= '0;
         inflight <= 1'b0;
         tag_rot  <= '0;
         fifo_mem <= '0;
         wptr     <= 1'b0;
         rptr     <= 1'b0;
         occ      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               state    <= LOAD;
               mode_q   <= bus.mode;
               busy     <= 1'b1;
               in_ready <= 1'b1;
               ld_i     <= '0;
               rd_j     <= '0;
               out_cnt  <= '0;
            end
            LOAD: if (in_hs) begin
               ld_i <= ld_i + 1'b1;
               if (&ld_i) begin
                  state    <= READ;
                  in_ready <= 1'b0;
               end
            end
            READ: if (pop) begin
               out_cnt <= out_cnt + 1'b1;
               if (&out_cnt) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         inflight <= issue;
         if (issue) begin
            rd_j    <= rd_j + 1'b1;
            tag_rot <= rd_j[1:0];
         end
         if (inflight) begin
            fifo_mem[wptr] <= cap;
            wptr           <= ~wptr;
         end
         if (pop)
            rptr <= ~rptr;
         occ <= occ + {1'b0, inflight} - {1'b0, pop};
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (occ != 2'd0);
   assign bus.out_d     = fifo_mem[rptr];
   assign bus.we        = we;
   assign bus.addr      = addr;
   assign bus.d         = d;
endmodule

// File: tb/tb_fsc_stream_ctrl.sv
// Scoreboard bench for fsc_stream_ctrl with a behavioural 4-bank FSC model.
module tb_fsc_stream_ctrl;
   typedef logic [3:0][63:0] beat_t;

   logic clk;
   logic rstn;
   fsc_stream_ctrl_if #(.DW(64), .AW(6)) bus ();

   fsc_stream_ctrl #(.DW(64), .AW(6)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FSC model: shared WE, registered read on every WE=0 cycle.
   logic [63:0] mem [4][64];
   beat_t       q_r;
   assign bus.q = q_r;
   always @(posedge clk) begin
      for (int n = 0; n < 4; n++) begin
         if (bus.we) mem[n][bus.addr[n]] <= bus.d[n];
         else        q_r[n] <= mem[n][bus.addr[n]];
      end
   end

   int    checks, errors;
   int    we_cnt, done_cnt, pop_cnt;
   bit    bp_out;
   beat_t sb[$];

   task automatic check(input bit ok, input string name, input logic [255:0] act,
                        input logic [255:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t exp_beat(input bit m, input int j);
      beat_t e;
      for (int b = 0; b < 4; b++)
         e[b] = m ? 64'(16 * (j / 4) + 4 * b + j % 4) : 64'(4 * j + b);
      return e;
   endfunction

   function automatic beat_t in_beat(input int i);
      beat_t v;
      for (int b = 0; b < 4; b++) v[b] = 64'(4 * i + b);
      return v;
   endfunction

   task automatic monitor();
      bit    stall = 0;
      beat_t stall_d = '0;
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            stall = 0;
         end else begin
            if (bus.we) we_cnt++;
            if (bus.done) begin
               done_cnt++;
               check(!bus.busy, "busy_low_at_done", 256'(bus.busy), 256'(0));
            end
            if (stall)
               check(bus.out_valid && bus.out_d == stall_d, "stall_stable",
                     bus.out_d, stall_d);
            if (bus.out_valid && bus.out_ready) begin
               pop_cnt++;
               if (sb.size() == 0) begin
                  check(0, "unexpected_beat", bus.out_d, 256'(0));
               end else begin
                  e = sb.pop_front();
                  check(bus.out_d == e, "out_beat", bus.out_d, e);
               end
            end
            stall   = bus.out_valid && !bus.out_ready;
            stall_d = bus.out_d;
         end
      end
   endtask

   task automatic ready_driver();
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = bp_out ? ($urandom_range(0, 9) < 3) : 1'b1;
      end
   endtask

   task automatic run_frame(input bit m, input bit bp_in, input bit bpo, input bit abort);
      int we0, d0, p0, i, guard, t;
      bit hs;
      beat_t exp6;
      we0 = we_cnt; d0 = done_cnt; p0 = pop_cnt;
      bp_out = bpo;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.mode  = m;
      for (int j = 0; j < 64; j++) sb.push_back(exp_beat(m, j));
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.mode  = ~m;
      i = 0; guard = 0;
      while (i < 64 && guard < 1000) begin
         bus.in_valid = bp_in ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_d     = in_beat(i);
         @(negedge clk);
         hs = bus.in_valid && bus.in_ready;
         if (hs && i == 6) begin
            exp6 = {64'd25, 64'd24, 64'd27, 64'd26};
            check(bus.we, "bank6_we", 256'(bus.we), 256'(1));
            check(bus.addr == {6'd6, 6'd6, 6'd6, 6'd6}, "bank6_addr",
                  256'(bus.addr), 256'({6'd6, 6'd6, 6'd6, 6'd6}));
            check(bus.d == exp6, "bank6_data", bus.d, exp6);
         end
         @(posedge clk); #1;
         if (hs) i++;
         guard++;
      end
      bus.in_valid = 1'b0;
      check(i == 64, "load_complete", 256'(i), 256'(64));
      if (!bp_in && !bpo) begin
         @(negedge clk); check(!bus.out_valid, "latency_c0", 256'(bus.out_valid), 256'(0));
         @(negedge clk); check(!bus.out_valid, "latency_c1", 256'(bus.out_valid), 256'(0));
         @(negedge clk); check(bus.out_valid,  "latency_c2", 256'(bus.out_valid), 256'(1));
      end
      if (abort) begin
         t = 0;
         while (pop_cnt - p0 < 30 && t < 2000) begin @(posedge clk); t++; end
         check(pop_cnt - p0 >= 30, "abort_reach", 256'(pop_cnt - p0), 256'(30));
         #1;
         rstn = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         sb.delete();
         rstn = 1'b1;
         repeat (3) @(posedge clk);
         check(done_cnt == d0, "abort_no_done", 256'(done_cnt - d0), 256'(0));
         @(negedge clk);
         check(!bus.busy && !bus.out_valid, "abort_idle",
               256'({bus.busy, bus.out_valid}), 256'(0));
      end else begin
         t = 0;
         while (done_cnt == d0 && t < 5000) begin @(posedge clk); t++; end
         check(done_cnt != d0, "done_seen", 256'(done_cnt - d0), 256'(1));
         repeat (2) @(posedge clk);
         check(done_cnt - d0 == 1, "done_once", 256'(done_cnt - d0), 256'(1));
         check(pop_cnt - p0 == 64, "beat_count", 256'(pop_cnt - p0), 256'(64));
         check(we_cnt - we0 == 64, "we_count", 256'(we_cnt - we0), 256'(64));
         check(sb.size() == 0, "sb_empty", 256'(sb.size()), 256'(0));
         check(!bus.busy, "busy_after", 256'(bus.busy), 256'(0));
      end
      bp_out = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      we_cnt = 0; done_cnt = 0; pop_cnt = 0;
      bp_out = 1'b0;
      rstn = 1'b0;
      bus.start = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_d = '0;
      bus.out_ready = 1'b1;
      fork
         monitor();
         ready_driver();
         begin
            #3_000_000;
            $display("FAIL watchdog expired");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset with random inputs
      repeat (3) begin
         @(posedge clk); #1;
         bus.start    = 1'($urandom_range(0, 1));
         bus.mode     = 1'($urandom_range(0, 1));
         bus.in_valid = 1'($urandom_range(0, 1));
         for (int b = 0; b < 4; b++) bus.in_d[b] = {$urandom, $urandom};
         @(negedge clk);
         check({bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.we} == 5'b0,
               "reset_ctrl", 256'({bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.we}),
               256'(0));
         check(bus.addr == '0 && bus.d == '0, "reset_bus", 256'(bus.addr) | bus.d, 256'(0));
         check(bus.out_d == '0, "reset_out_d", bus.out_d, 256'(0));
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_d = '0;
      rstn = 1'b1;
      @(negedge clk);
      check(!bus.in_ready && !bus.busy, "idle_after_reset",
            256'({bus.in_ready, bus.busy}), 256'(0));

      run_frame(1'b0, 1'b0, 1'b0, 1'b0);   // direct
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);   // transpose
      run_frame(1'b0, 1'b1, 1'b1, 1'b0);   // direct, backpressure
      run_frame(1'b1, 1'b1, 1'b1, 1'b0);   // transpose, backpressure
      run_frame(1'b0, 1'b0, 1'b0, 1'b1);   // aborted by reset
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);   // clean frame after abort

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
